lsu_stage: RTL and testbench
============================

Name: lsu_stage

Overview:
- Memory-access stage (M) sitting directly downstream of the execute stage.
- Consumes the execute result: the ALU result is the effective address for loads and stores, or the writeback value for all other ops.
- Issues at most one data-memory transaction per instruction over a valid/ready request/response bus.
- Delivers a registered result to the W stage through a valid/ready handshake.

Parameters:
- XLEN, 32, datapath and address width.
- ADDR_LSB, 2, log2(XLEN/8); byte-offset bits within a word.

Ports:
- clock  in  1  stage clock
- reset_n  in  1  asynchronous active-low reset
- M_valid_i  in  1  instruction valid from the E/M pipe
- m_ready_o  out  1  stage can accept an instruction
- is_load_i  in  1  instruction is a load
- is_store_i  in  1  instruction is a store
- funct3_i  in  3  access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU)
- res_i  in  XLEN  execute result (address for load/store)
- src2_i  in  XLEN  store data
- rd_i  in  5  destination register index
- wen_i  in  1  register-write enable
- dmem_req_valid_o  out  1  memory request valid
- dmem_req_ready_i  in  1  memory accepts request
- dmem_req_wen_o  out  1  1 = write
- dmem_req_addr_o  out  XLEN  word-aligned address
- dmem_req_wdata_o  out  XLEN  lane-aligned store data
- dmem_req_wmask_o  out  XLEN/8  byte strobes
- dmem_resp_valid_i  in  1  response valid (always accepted)
- dmem_resp_rdata_i  in  XLEN  read word
- m_valid_o  out  1  result valid to W
- W_ready_i  in  1  W stage accepts
- res_o  out  XLEN  writeback value
- rd_o  out  5  destination register index
- wen_o  out  1  register-write enable
- misalign_o  out  1  misaligned-access flag (0 when the optional feature is off)

Behaviour:
- Reset (asynchronous, active-low): state=IDLE; m_valid_o=0, dmem_req_valid_o=0, res_o=0, rd_o=0, wen_o=0, misalign_o=0, all other request outputs=0. Asserting reset_n low mid-transaction returns to IDLE immediately; a response arriving after reset is ignored.
- States:
  - IDLE: waiting for an instruction.
  - REQ: dmem_req_valid_o=1.
  - WAIT: awaiting response.
  - DONE: m_valid_o=1.
- Handshake: m_ready_o = (state==IDLE) || (state==DONE && W_ready_i). An instruction is accepted on M_valid_i && m_ready_o.
- Accept of a non-memory op: res_o/rd_o/wen_o registered from res_i/rd_i/wen_i; next state=DONE (1-cycle latency).
- Accept of a load/store: address, data, size and rd are captured; next state=REQ.
- REQ: request fields are stable while dmem_req_valid_o=1. On dmem_req_ready_i, go to WAIT. A response in the same cycle as request acceptance is legal; it is handled as in WAIT and the state goes to DONE.
- WAIT: on dmem_resp_valid_i:
  - load: res_o = extended lane data.
  - store: res_o unchanged (wen_o=0).
  - next state=DONE.
- DONE: hold all outputs until W_ready_i. Then go to IDLE, or go straight to DONE/REQ if a new instruction is accepted in the same cycle (back-to-back, no bubble).
- Store alignment:
  - wmask: B=0001, H=0011, W=1111, each shifted left by addr[1:0].
  - wdata = src2 shifted left by 8*addr[1:0].
  - dmem_req_addr_o = {addr[XLEN-1:2], 2'b00}.
- Load extraction:
  - lane = rdata >> 8*addr[1:0].
  - B/H are sign-extended; BU/HU are zero-extended; W is passed through.
  - Undefined funct3 values are treated as W.
- M_valid_i with is_load_i && is_store_i both set is illegal; behaviour is unspecified and flagged by a simulation assertion.

Optional Feature:
- Macro LSU_MISALIGN_CHECK_EN.
- Defined: an H access with addr[0]!=0, or a W access with addr[1:0]!=0, issues no bus request. The stage goes straight to DONE with misalign_o=1, wen_o=0, and res_o = faulting address.
- Undefined: misalign_o is tied to 0; low address bits only select lanes, and bytes outside the word are dropped.

Decomposition:
- Shared package holds:
  - the funct3 size/sign encodings;
  - the 2-bit state encoding (IDLE=0, REQ=1, WAIT=2, DONE=3);
  - the XLEN and ADDR_LSB constants.
- One combinational sub-module, lsu_align: store wdata/wmask generation and load extraction, from (funct3, addr[1:0], data).

Test Plan:
- Non-memory op with res_i=0x1234, rd=5, W_ready_i=1 -> m_valid_o one cycle later; res_o=0x1234, rd_o=5, no bus request.
- SB with addr=0x80000003, src2=0xAB -> wmask=1000, wdata=0xAB000000, addr_o=0x80000000, wen=1.
- LB at addr 0x...01 with rdata=0x0000_8000 -> res_o=0xFFFFFF80. Same with LBU -> 0x00000080.
- dmem_req_ready_i low for 3 cycles, then response delayed 2 cycles with W_ready_i low -> request fields stable throughout; m_valid_o held until W_ready_i.
- Back-to-back loads with W_ready_i=1 -> second accepted in the DONE cycle; no idle bubble. Reset asserted in WAIT -> outputs zero immediately; the late response is ignored.
- With LSU_MISALIGN_CHECK_EN: LW at 0x...02 -> no dmem_req_valid_o, misalign_o=1, res_o=address.

Source files
------------

// File: rtl/lsu_stage_pkg.sv
// lsu_stage_pkg
//   Shared definitions for the memory-access stage:
//   - datapath constants (LSU_XLEN, LSU_ADDR_LSB)
//   - funct3 size/sign encodings and their decoded access size
//   - 2-bit FSM state encoding (IDLE=0, REQ=1, WAIT=2, DONE=3)
package lsu_stage_pkg;

    localparam int LSU_XLEN     = 32;
    localparam int LSU_ADDR_LSB = 2;

    // funct3 encodings for loads/stores
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } access_size_e;

    // Low two funct3 bits give the size; bit 2 only selects zero-extension.
    // Every encoding that is not B/H/BU/HU falls through to a full word.
    function automatic access_size_e f3_size(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return SZ_BYTE;
            2'b01:   return SZ_HALF;
            default: return SZ_WORD;
        endcase
    endfunction

endpackage

// File: rtl/lsu_stage_align.sv
// lsu_align
//   Combinational lane alignment for the memory-access stage.
//   Ports:
//     funct3     - access size/sign
//     offset     - byte offset of the access within the word
//     store_data - register value to be stored
//     load_word  - word returned by data memory
//     wdata      - store data shifted into its byte lanes
//     wmask      - byte strobes of the store
//     load_data  - extracted and sign/zero-extended load value
//   Bytes that would fall beyond the word boundary are simply dropped.
module lsu_align
    import lsu_stage_pkg::*;
#(
    parameter int XLEN     = LSU_XLEN,
    parameter int ADDR_LSB = LSU_ADDR_LSB
) (
    input  logic [2:0]          funct3,
    input  logic [ADDR_LSB-1:0] offset,
    input  logic [XLEN-1:0]     store_data,
    input  logic [XLEN-1:0]     load_word,
    output logic [XLEN-1:0]     wdata,
    output logic [XLEN/8-1:0]   wmask,
    output logic [XLEN-1:0]     load_data
);

    access_size_e          size;
    logic [ADDR_LSB+2:0]   bit_shift;
    logic [XLEN/8-1:0]     base_mask;
    logic [XLEN-1:0]       lane;
    logic                  sign_ext;

    assign size      = f3_size(funct3);
    assign bit_shift = {offset, 3'b000};
    assign sign_ext  = ~funct3[2];

    always_comb begin
        base_mask = '0;
        case (size)
            SZ_BYTE: base_mask[0]   = 1'b1;
            SZ_HALF: base_mask[1:0] = 2'b11;
            default: base_mask      = '1;
        endcase
    end

    assign wmask = base_mask << offset;
    assign wdata = store_data << bit_shift;
    assign lane  = load_word >> bit_shift;

    always_comb begin
        case (size)
            SZ_BYTE: load_data = {{(XLEN-8){sign_ext & lane[7]}}, lane[7:0]};
            SZ_HALF: load_data = {{(XLEN-16){sign_ext & lane[15]}}, lane[15:0]};
            default: load_data = lane;
        endcase
    end

endmodule

// File: rtl/lsu_stage.sv
// lsu_stage
//   Memory-access pipeline stage. Takes the execute result, issues at most
//   one data-memory transaction per instruction and hands a registered
//   result to writeback.
//   Ports:
//     clock, reset_n            - stage clock, asynchronous active-low reset
//     M_valid_i / m_ready_o     - instruction handshake from E/M
//     is_load_i, is_store_i, funct3_i, res_i, src2_i, rd_i, wen_i
//                               - instruction fields (res_i is the address
//                                 for loads/stores)
//     dmem_req_*                - memory request channel (valid/ready)
//     dmem_resp_*               - memory response (always accepted)
//     m_valid_o / W_ready_i     - result handshake to W
//     res_o, rd_o, wen_o        - writeback payload
//     misalign_o                - misaligned-access flag
//   Build option: define LSU_MISALIGN_CHECK_EN to trap misaligned H/W
//   accesses without touching the bus; otherwise misalign_o is tied low.
module lsu_stage
    import lsu_stage_pkg::*;
#(
    parameter int XLEN     = LSU_XLEN,
    parameter int ADDR_LSB = LSU_ADDR_LSB
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              M_valid_i,
    output logic              m_ready_o,
    input  logic              is_load_i,
    input  logic              is_store_i,
    input  logic [2:0]        funct3_i,
    input  logic [XLEN-1:0]   res_i,
    input  logic [XLEN-1:0]   src2_i,
    input  logic [4:0]        rd_i,
    input  logic              wen_i,
    output logic              dmem_req_valid_o,
    input  logic              dmem_req_ready_i,
    output logic              dmem_req_wen_o,
    output logic [XLEN-1:0]   dmem_req_addr_o,
    output logic [XLEN-1:0]   dmem_req_wdata_o,
    output logic [XLEN/8-1:0] dmem_req_wmask_o,
    input  logic              dmem_resp_valid_i,
    input  logic [XLEN-1:0]   dmem_resp_rdata_i,
    output logic              m_valid_o,
    input  logic              W_ready_i,
    output logic [XLEN-1:0]   res_o,
    output logic [4:0]        rd_o,
    output logic              wen_o,
    output logic              misalign_o
);

    logic [1:0]        state_reg, state_next;
    logic [XLEN-1:0]   addr_reg, sdata_reg, res_reg;
    logic [2:0]        funct3_reg;
    logic              is_store_reg;
    logic [4:0]        rd_reg;
    logic              wen_reg, misalign_reg;

    logic              accept, is_mem, misalign_det;
    logic              req_active, req_fire, resp_take;
    logic [XLEN-1:0]   align_wdata, align_load;
    logic [XLEN/8-1:0] align_wmask;

    assign m_ready_o  = (state_reg == ST_IDLE) || ((state_reg == ST_DONE) && W_ready_i);
    assign accept     = M_valid_i && m_ready_o;
    assign is_mem     = is_load_i || is_store_i;
    assign req_active = (state_reg == ST_REQ);
    assign req_fire   = req_active && dmem_req_ready_i;
    // A response may arrive in the very cycle the request is taken.
    assign resp_take  = dmem_resp_valid_i && (req_fire || (state_reg == ST_WAIT));

`ifdef LSU_MISALIGN_CHECK_EN
    always_comb begin
        case (f3_size(funct3_i))
            SZ_HALF: misalign_det = res_i[0];
            SZ_WORD: misalign_det = |res_i[ADDR_LSB-1:0];
            default: misalign_det = 1'b0;
        endcase
    end
`else
    assign misalign_det = 1'b0;
`endif

    lsu_align #(
        .XLEN     (XLEN),
        .ADDR_LSB (ADDR_LSB)
    ) u_align (
        .funct3     (funct3_reg),
        .offset     (addr_reg[ADDR_LSB-1:0]),
        .store_data (sdata_reg),
        .load_word  (dmem_resp_rdata_i),
        .wdata      (align_wdata),
        .wmask      (align_wmask),
        .load_data  (align_load)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_REQ:  if (req_fire)  state_next = resp_take ? ST_DONE : ST_WAIT;
            ST_WAIT: if (resp_take) state_next = ST_DONE;
            ST_DONE: if (W_ready_i) state_next = ST_IDLE;
            default: state_next = state_reg;
        endcase
        // Acceptance in DONE overrides the return to IDLE (no bubble).
        if (accept) begin
            state_next = (is_mem && !misalign_det) ? ST_REQ : ST_DONE;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= ST_IDLE;
            addr_reg     <= '0;
            sdata_reg    <= '0;
            funct3_reg   <= '0;
            is_store_reg <= 1'b0;
            res_reg      <= '0;
            rd_reg       <= '0;
            wen_reg      <= 1'b0;
            misalign_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                rd_reg       <= rd_i;
                misalign_reg <= is_mem && misalign_det;
                if (!is_mem) begin
                    res_reg <= res_i;
                    wen_reg <= wen_i;
                end else if (misalign_det) begin
                    // Trapped access: report the faulting address, no write.
                    res_reg <= res_i;
                    wen_reg <= 1'b0;
                end else begin
                    addr_reg     <= res_i;
                    sdata_reg    <= src2_i;
                    funct3_reg   <= funct3_i;
                    is_store_reg <= is_store_i;
                    wen_reg      <= is_load_i && wen_i;
                end
            end else if (resp_take && !is_store_reg) begin
                res_reg <= align_load;
            end
        end
    end

    // Request fields come straight from captured registers, so they are
    // stable for as long as the request is pending; they read as zero
    // whenever no request is outstanding.
    assign dmem_req_valid_o = req_active;
    assign dmem_req_wen_o   = req_active && is_store_reg;
    assign dmem_req_addr_o  = req_active ? {addr_reg[XLEN-1:ADDR_LSB], {ADDR_LSB{1'b0}}} : '0;
    assign dmem_req_wdata_o = (req_active && is_store_reg) ? align_wdata : '0;
    assign dmem_req_wmask_o = (req_active && is_store_reg) ? align_wmask : '0;

    assign m_valid_o  = (state_reg == ST_DONE);
    assign res_o      = res_reg;
    assign rd_o       = rd_reg;
    assign wen_o      = wen_reg;
    assign misalign_o = misalign_reg;

    illegal_load_and_store: assert property (@(posedge clock) disable iff (!reset_n)
        !(M_valid_i && is_load_i && is_store_i));

endmodule

// File: tb/tb_lsu_stage.sv
module tb_lsu_stage;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        M_valid_i, m_ready_o, is_load_i, is_store_i, wen_i;
    logic [2:0]  funct3_i;
    logic [31:0] res_i, src2_i;
    logic [4:0]  rd_i;
    logic        dmem_req_valid_o, dmem_req_ready_i, dmem_req_wen_o;
    logic [31:0] dmem_req_addr_o, dmem_req_wdata_o;
    logic [3:0]  dmem_req_wmask_o;
    logic        dmem_resp_valid_i;
    logic [31:0] dmem_resp_rdata_i;
    logic        m_valid_o, W_ready_i, wen_o, misalign_o;
    logic [31:0] res_o;
    logic [4:0]  rd_o;

    int checks = 0;
    int errors = 0;

    // Architectural expectation of the W-stage payload
    logic [31:0] exp_res;
    logic [4:0]  exp_rd;
    logic        exp_wen, exp_mis;

    always #5 clock = ~clock;

    lsu_stage #(.XLEN(32), .ADDR_LSB(2)) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .M_valid_i         (M_valid_i),
        .m_ready_o         (m_ready_o),
        .is_load_i         (is_load_i),
        .is_store_i        (is_store_i),
        .funct3_i          (funct3_i),
        .res_i             (res_i),
        .src2_i            (src2_i),
        .rd_i              (rd_i),
        .wen_i             (wen_i),
        .dmem_req_valid_o  (dmem_req_valid_o),
        .dmem_req_ready_i  (dmem_req_ready_i),
        .dmem_req_wen_o    (dmem_req_wen_o),
        .dmem_req_addr_o   (dmem_req_addr_o),
        .dmem_req_wdata_o  (dmem_req_wdata_o),
        .dmem_req_wmask_o  (dmem_req_wmask_o),
        .dmem_resp_valid_i (dmem_resp_valid_i),
        .dmem_resp_rdata_i (dmem_resp_rdata_i),
        .m_valid_o         (m_valid_o),
        .W_ready_i         (W_ready_i),
        .res_o             (res_o),
        .rd_o              (rd_o),
        .wen_o             (wen_o),
        .misalign_o        (misalign_o)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model (plain arithmetic) ----------------
    function automatic int nbytes(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    function automatic logic [3:0] m_wmask(input logic [2:0] f3, input logic [31:0] addr);
        int off = int'(addr % 4);
        int m   = ((1 << nbytes(f3)) - 1) << off;
        return 4'(m & 15);
    endfunction

    function automatic logic [31:0] m_wdata(input logic [31:0] src2, input logic [31:0] addr);
        longint w = longint'(src2) * (longint'(1) << (8 * int'(addr % 4)));
        return 32'(w);
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] rdata);
        longint lane = longint'(rdata) / (longint'(1) << (8 * int'(addr % 4)));
        int     n    = nbytes(f3);
        longint span = longint'(1) << (8 * n);
        longint val;
        if (n == 4) return 32'(lane);
        val = lane % span;
        if ((f3 == 3'b000 || f3 == 3'b001) && val >= span / 2) val = val - span;
        return 32'(val);
    endfunction

    function automatic bit m_misaligned(input logic [2:0] f3, input logic [31:0] addr);
`ifdef LSU_MISALIGN_CHECK_EN
        return (addr % 32'(nbytes(f3))) != 0;
`else
        return 1'b0;
`endif
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_done();
        chk("m_valid", 32'(m_valid_o), 1);
        chk("res_o", res_o, exp_res);
        chk("rd_o", 32'(rd_o), 32'(exp_rd));
        chk("wen_o", 32'(wen_o), 32'(exp_wen));
        chk("misalign_o", 32'(misalign_o), 32'(exp_mis));
        chk("no_req_in_done", 32'(dmem_req_valid_o), 0);
    endtask

    task automatic check_req(input bit ld, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] src2);
        chk("req_valid", 32'(dmem_req_valid_o), 1);
        chk("req_addr", dmem_req_addr_o, addr - (addr % 4));
        chk("req_wen", 32'(dmem_req_wen_o), 32'(!ld));
        chk("out_not_valid", 32'(m_valid_o), 0);
        if (!ld) begin
            chk("req_wmask", 32'(dmem_req_wmask_o), 32'(m_wmask(f3, addr)));
            chk("req_wdata", dmem_req_wdata_o, m_wdata(src2, addr));
        end
    endtask

    // Drives one instruction for one clock; caller sets W_ready_i beforehand.
    task automatic issue(input bit ld, input bit st, input logic [2:0] f3, input logic [31:0] res,
                         input logic [31:0] src2, input logic [4:0] rd, input bit wen);
        M_valid_i = 1'b1; is_load_i = ld; is_store_i = st; funct3_i = f3;
        res_i = res; src2_i = src2; rd_i = rd; wen_i = wen;
        #1;
        chk("accept_ready", 32'(m_ready_o), 1);
        @(negedge clock);
        M_valid_i = 1'b0; is_load_i = 1'b0; is_store_i = 1'b0;
        res_i = $urandom; src2_i = $urandom; rd_i = 5'($urandom); funct3_i = 3'($urandom);
    endtask

    task automatic retire();
        W_ready_i = 1'b1;
        @(negedge clock);
        W_ready_i = 1'b0;
        chk("retired_idle", 32'(m_valid_o), 0);
        chk("idle_ready", 32'(m_ready_o), 1);
    endtask

    task automatic alu_op(input logic [31:0] res, input logic [4:0] rd, input bit wen);
        issue(1'b0, 1'b0, 3'($urandom_range(0, 7)), res, $urandom, rd, wen);
        W_ready_i = 1'b0;
        exp_res = res; exp_rd = rd; exp_wen = wen; exp_mis = 1'b0;
        check_done();
    endtask

    task automatic mem_op(input bit ld, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] src2, input logic [4:0] rd, input bit wen,
                          input logic [31:0] rdata, input int req_wait, input int resp_wait,
                          input int hold);
        issue(ld, !ld, f3, addr, src2, rd, wen);
        W_ready_i = 1'b0;
        if (m_misaligned(f3, addr)) begin
            exp_res = addr; exp_rd = rd; exp_wen = 1'b0; exp_mis = 1'b1;
        end else begin
            for (int i = 0; i < req_wait; i++) begin
                check_req(ld, f3, addr, src2);
                @(negedge clock);
            end
            check_req(ld, f3, addr, src2);
            dmem_req_ready_i = 1'b1;
            if (resp_wait == 0) begin
                dmem_resp_valid_i = 1'b1;
                dmem_resp_rdata_i = rdata;
            end
            @(negedge clock);
            dmem_req_ready_i  = 1'b0;
            dmem_resp_valid_i = 1'b0;
            if (resp_wait > 0) begin
                for (int i = 0; i < resp_wait; i++) begin
                    dmem_resp_rdata_i = $urandom;
                    chk("wait_no_valid", 32'(m_valid_o), 0);
                    chk("wait_no_req", 32'(dmem_req_valid_o), 0);
                    @(negedge clock);
                end
                dmem_resp_valid_i = 1'b1;
                dmem_resp_rdata_i = rdata;
                @(negedge clock);
                dmem_resp_valid_i = 1'b0;
            end
            exp_rd = rd; exp_mis = 1'b0;
            if (ld) begin
                exp_res = m_load(f3, addr, rdata);
                exp_wen = wen;
            end else begin
                exp_wen = 1'b0;
            end
        end
        check_done();
        for (int i = 0; i < hold; i++) begin
            dmem_resp_rdata_i = $urandom;
            @(negedge clock);
            check_done();
        end
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        reset_n = 1'b0;
        M_valid_i = 1'b0; is_load_i = 1'b0; is_store_i = 1'b0; funct3_i = '0;
        res_i = '0; src2_i = '0; rd_i = '0; wen_i = 1'b0;
        dmem_req_ready_i = 1'b0; dmem_resp_valid_i = 1'b0; dmem_resp_rdata_i = '0;
        W_ready_i = 1'b0;
        exp_res = '0; exp_rd = '0; exp_wen = 1'b0; exp_mis = 1'b0;
        repeat (2) @(negedge clock);

        chk("rst_m_valid", 32'(m_valid_o), 0);
        chk("rst_req_valid", 32'(dmem_req_valid_o), 0);
        chk("rst_res", res_o, 0);
        chk("rst_rd", 32'(rd_o), 0);
        chk("rst_wen", 32'(wen_o), 0);
        chk("rst_misalign", 32'(misalign_o), 0);
        chk("rst_req_wen", 32'(dmem_req_wen_o), 0);
        chk("rst_req_addr", dmem_req_addr_o, 0);
        chk("rst_req_wmask", 32'(dmem_req_wmask_o), 0);
        reset_n = 1'b1;
        @(negedge clock);

        // Non-memory op: one-cycle latency, no bus traffic
        W_ready_i = 1'b1;
        alu_op(32'h0000_1234, 5'd5, 1'b1);
        chk("alu_res_const", res_o, 32'h0000_1234);
        chk("alu_rd_const", 32'(rd_o), 5);
        retire();

        // SB at byte 3
        W_ready_i = 1'b1;
        issue(1'b0, 1'b1, 3'b000, 32'h8000_0003, 32'h0000_00AB, 5'd7, 1'b1);
        W_ready_i = 1'b0;
        chk("sb_req_valid", 32'(dmem_req_valid_o), 1);
        chk("sb_addr", dmem_req_addr_o, 32'h8000_0000);
        chk("sb_wdata", dmem_req_wdata_o, 32'hAB00_0000);
        chk("sb_wmask", 32'(dmem_req_wmask_o), 32'h8);
        chk("sb_req_wen", 32'(dmem_req_wen_o), 1);
        dmem_req_ready_i = 1'b1; dmem_resp_valid_i = 1'b1; dmem_resp_rdata_i = 32'hFFFF_FFFF;
        @(negedge clock);
        dmem_req_ready_i = 1'b0; dmem_resp_valid_i = 1'b0;
        exp_rd = 5'd7; exp_wen = 1'b0; exp_mis = 1'b0;
        check_done();
        chk("sb_res_kept", res_o, 32'h0000_1234);
        retire();

        // LB / LBU of a byte with its top bit set
        mem_op(1'b1, 3'b000, 32'h4000_0001, 32'h0, 5'd9, 1'b1, 32'h0000_8000, 0, 1, 0);
        chk("lb_const", res_o, 32'hFFFF_FF80);
        retire();
        mem_op(1'b1, 3'b100, 32'h4000_0001, 32'h0, 5'd9, 1'b1, 32'h0000_8000, 0, 1, 0);
        chk("lbu_const", res_o, 32'h0000_0080);
        retire();

        // Request back-pressure, late response, W stall
        mem_op(1'b1, 3'b010, 32'h0000_0100, 32'h0, 5'd3, 1'b1, 32'hDEAD_BEEF, 3, 2, 2);
        chk("lw_stall_const", res_o, 32'hDEAD_BEEF);

        // Back-to-back: next load accepted in the DONE cycle
        W_ready_i = 1'b1;
        mem_op(1'b1, 3'b001, 32'h0000_0202, 32'h0, 5'd4, 1'b1, 32'h8001_0000, 0, 0, 0);
        chk("lh_b2b_const", res_o, 32'hFFFF_8001);

`ifdef LSU_MISALIGN_CHECK_EN
        W_ready_i = 1'b1;
        mem_op(1'b1, 3'b010, 32'h1000_0002, 32'h0, 5'd6, 1'b1, 32'h0, 0, 0, 0);
        chk("mis_flag_const", 32'(misalign_o), 1);
        chk("mis_res_const", res_o, 32'h1000_0002);
`endif

        // Reset while waiting for a response; the late response is dropped
        retire();
        issue(1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'h0, 5'd8, 1'b1);
        dmem_req_ready_i = 1'b1;
        @(negedge clock);
        dmem_req_ready_i = 1'b0;
        chk("wait_state_no_req", 32'(dmem_req_valid_o), 0);
        reset_n = 1'b0;
        #1;
        chk("async_rst_m_valid", 32'(m_valid_o), 0);
        chk("async_rst_res", res_o, 0);
        chk("async_rst_rd", 32'(rd_o), 0);
        chk("async_rst_wen", 32'(wen_o), 0);
        chk("async_rst_req", 32'(dmem_req_valid_o), 0);
        @(negedge clock);
        reset_n = 1'b1;
        dmem_resp_valid_i = 1'b1; dmem_resp_rdata_i = 32'hFFFF_FFFF;
        @(negedge clock);
        dmem_resp_valid_i = 1'b0;
        exp_res = '0; exp_rd = '0; exp_wen = 1'b0; exp_mis = 1'b0;
        chk("late_resp_ignored_valid", 32'(m_valid_o), 0);
        chk("late_resp_ignored_res", res_o, 0);
        chk("late_resp_idle_ready", 32'(m_ready_o), 1);

        // Randomized mix of ALU ops, loads and stores
        for (int k = 0; k < 40; k++) begin
            int kind;
            bit ld;
            logic [2:0] f3;
            kind = $urandom_range(0, 2);
            if ($urandom_range(0, 1) == 1) retire();
            W_ready_i = 1'b1;
            if (kind == 0) begin
                alu_op($urandom, 5'($urandom), 1'($urandom));
            end else begin
                ld = (kind == 1);
                f3 = ld ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 2));
                mem_op(ld, f3, $urandom, $urandom, 5'($urandom), 1'($urandom), $urandom,
                       $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 1));
            end
        end
        retire();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
